serial_sub_unit: RTL and testbench

//  Parametrised multi-cycle subtractor: computes diff = a - b - brow_in over WIDTH bits,

---
 rtl/serial_sub_pkg.sv | 22 ++
 rtl/sub_slice.sv | 23 ++
 rtl/serial_sub_unit.sv | 125 ++++++++++++
 tb/tb_serial_sub_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and elaboration helpers for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Never returns less than 1 so a single-step counter still has a bit to hold.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational ripple-borrow chain of N full-subtractor cells
module sub_slice #(
    parameter int N = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout
);

    always_comb begin : p_chain
        logic br;
        br = bin;
        d  = '0;
        for (int i = 0; i < N; i++) begin
            d[i] = a[i] ^ b[i] ^ br;
            br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_sub_unit.sv
// rtl/serial_sub_unit.sv - multi-cycle a - b - brow_in, BITS_PER_CYCLE bits per clock
module serial_sub_unit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             brow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             brow_out,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = clog2(STEPS);

    generate
        if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
            $error("serial_sub_unit: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    state_t                    state;
    state_t                    state_nx;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    logic [WIDTH-1:0]          res_sh;
    logic [WIDTH-1:0]          res_nx;
    logic                      borrow;
    logic [CW-1:0]             cnt;
    logic                      a_msb;
    logic                      b_msb;
    logic                      last_step;
    logic [BITS_PER_CYCLE-1:0] sl_d;
    logic                      sl_bout;

    sub_slice #(
        .N(BITS_PER_CYCLE)
    ) u_slice (
        .a   (a_sh[BITS_PER_CYCLE-1:0]),
        .b   (b_sh[BITS_PER_CYCLE-1:0]),
        .bin (borrow),
        .d   (sl_d),
        .bout(sl_bout)
    );

    // Slice results enter at the MSB end, so after STEPS shifts the LSB slice sits at bit 0.
    assign res_nx    = WIDTH'({sl_d, res_sh} >> BITS_PER_CYCLE);
    assign last_step = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last_step) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            brow_out <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= brow_in;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> BITS_PER_CYCLE;
                    b_sh   <= b_sh >> BITS_PER_CYCLE;
                    res_sh <= res_nx;
                    borrow <= sl_bout;
                    cnt    <= cnt + CW'(1);
                    // Visible outputs change only here, so partial shifts never leak out.
                    if (last_step) begin
                        diff     <= res_nx;
                        brow_out <= sl_bout;
                        ovf      <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
                        zero     <= ~|res_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// tb/tb_serial_sub_unit.sv - randomized self-checking bench for serial_sub_unit
module tb_serial_sub_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       bin_in;
    logic       start8, start84, start1;

    logic       busy8, done8, bo8, ovf8, zero8;
    logic [7:0] diff8;
    logic       busy84, done84, bo84, ovf84, zero84;
    logic [7:0] diff84;
    logic       busy1, done1, bo1, ovf1, zero1;
    logic [0:0] diff1;

    int errors = 0;
    int checks = 0;
    int osel = 0;
    logic [7:0] prev_exp8 = 8'h00;

    logic       o_busy, o_done, o_bo, o_ovf, o_zero;
    logic [7:0] o_diff;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a_in), .b(b_in), .brow_in(bin_in),
        .busy(busy8), .done(done8), .diff(diff8), .brow_out(bo8), .ovf(ovf8), .zero(zero8)
    );

    serial_sub_unit #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut84 (
        .clk(clk), .rst_n(rst_n), .start(start84), .a(a_in), .b(b_in), .brow_in(bin_in),
        .busy(busy84), .done(done84), .diff(diff84), .brow_out(bo84), .ovf(ovf84), .zero(zero84)
    );

    serial_sub_unit #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a_in[0:0]), .b(b_in[0:0]), .brow_in(bin_in),
        .busy(busy1), .done(done1), .diff(diff1), .brow_out(bo1), .ovf(ovf1), .zero(zero1)
    );

    always_comb begin
        o_busy = busy8; o_done = done8; o_diff = diff8; o_bo = bo8; o_ovf = ovf8; o_zero = zero8;
        if (osel == 1) begin
            o_busy = busy84; o_done = done84; o_diff = diff84; o_bo = bo84; o_ovf = ovf84; o_zero = zero84;
        end else if (osel == 2) begin
            o_busy = busy1; o_done = done1; o_diff = {7'b0, diff1}; o_bo = bo1; o_ovf = ovf1; o_zero = zero1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction on w bits; returns {ovf, zero, brow_out, diff}.
    function automatic logic [10:0] ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                            input logic bin);
        int mask, t, d;
        logic bo, am, bm, dm;
        mask = (1 << w) - 1;
        t  = (int'(a) & mask) - (int'(b) & mask) - int'(bin);
        d  = t & mask;
        bo = (t < 0);
        am = ((int'(a) >> (w - 1)) & 1) != 0;
        bm = ((int'(b) >> (w - 1)) & 1) != 0;
        dm = ((d >> (w - 1)) & 1) != 0;
        return {(am != bm) && (dm != am), (d == 0), bo, d[7:0]};
    endfunction

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start8 = v;
        else if (sel == 1) start84 = v;
        else start1 = v;
    endtask

    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic mid_start);
        int lat;
        int nsteps;
        logic [10:0] exp;
        nsteps = (sel == 0) ? 8 : ((sel == 1) ? 2 : 1);
        exp    = ref_sub((sel == 2) ? 1 : 8, a, b, bin);
        osel   = sel;
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bin;
        drive_start(sel, 1'b1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        drive_start(sel, mid_start);
        while (!o_done && lat < 40) begin
            check("busy_run", o_busy, 1);
            if (sel == 0) check("diff_hold", o_diff, prev_exp8);
            a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done_seen", o_done, 1);
        check("latency", lat, nsteps + 1);
        check("busy_done", o_busy, 1);
        check("diff", o_diff, exp[7:0]);
        check("brow_out", o_bo, exp[8]);
        check("zero", o_zero, exp[9]);
        check("ovf", o_ovf, exp[10]);
        if (sel == 0) prev_exp8 = exp[7:0];
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int dones;
        rst_n = 1'b0;
        start8 = 1'b0; start84 = 1'b0; start1 = 1'b0;
        a_in = 8'h00; b_in = 8'h00; bin_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_8",  {busy8, done8, bo8, ovf8, zero8, diff8}, 0);
        check("rst_84", {busy84, done84, bo84, ovf84, zero84, diff84}, 0);
        check("rst_1",  {busy1, done1, bo1, ovf1, zero1, diff1}, 0);
        rst_n = 1'b1;

        do_op(0, 8'h05, 8'h03, 1'b0, 1'b0);
        do_op(0, 8'h03, 8'h05, 1'b0, 1'b0);
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b0);
        do_op(0, 8'h00, 8'h00, 1'b1, 1'b0);
        do_op(0, 8'h2A, 8'h2A, 1'b0, 1'b0);

        // start held through RUN and DONE must not yield a second operation
        do_op(1, 8'h5A, 8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        check("busy_after_done", busy84, 0);
        drive_start(1, 1'b0);
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done84) dones++;
        end
        check("no_extra_done", dones, 0);

        // continuously asserted start: one op every STEPS+2 cycles
        osel = 1;
        @(negedge clk);
        start84 = 1'b1;
        n = 0;
        while (!done84 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        check("held_first_done", done84, 1);
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (!done84 && n < 20);
        check("held_period", n, 4);
        start84 = 1'b0;
        repeat (4) @(negedge clk);

        // reset asserted mid-RUN
        osel = 0;
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h11; bin_in = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {busy8, done8, bo8, ovf8, zero8, diff8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) dones++;
        end
        check("abort_no_done", dones, 0);
        prev_exp8 = 8'h00;
        do_op(0, 8'h9C, 8'h47, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0);
        end

        for (int k = 0; k < 1000; k++) begin
            int s;
            s = (k % 4 == 3) ? 1 : 0;
            do_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
